// File: rtl/sdram_device_emulator.sv
// SDR SDRAM device emulator: decodes the controller command bus,
// tracks banks, serves bursts from backing RAM and flags violations.
module sdram_device_emulator #(
    parameter int ROW_ADDR_WIDTH  = 12,
    parameter int BANK_ADDR_WIDTH = 2,
    parameter int COL_ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH      = 16,
    parameter int MEM_ADDR_WIDTH  = 12,
    parameter int T_RCD           = 3,
    parameter int T_RP            = 3
) (
    input  logic                          i_Clk,
    input  logic                          i_Reset_n,
    inout  wire  [DATA_WIDTH-1:0]         b_Dq,
    input  logic [ROW_ADDR_WIDTH-1:0]     i_Addr,
    input  logic [BANK_ADDR_WIDTH-1:0]    i_Ba,
    input  logic                          i_Cke,
    input  logic                          i_Cs_n,
    input  logic                          i_Ras_n,
    input  logic                          i_Cas_n,
    input  logic                          i_We_n,
    input  logic [DATA_WIDTH/8-1:0]       i_Dqm,
    output logic                          o_Mode_Valid,
    output logic [2**BANK_ADDR_WIDTH-1:0] o_Open_Banks,
    output logic                          o_Err_Pulse,
    output logic [2:0]                    o_Err_Code,
    output logic [15:0]                   o_Refresh_Count
);
    localparam int NB = 2**BANK_ADDR_WIDTH;
    localparam int NL = DATA_WIDTH/8;
    localparam logic [7:0] RCD8 = 8'(T_RCD);
    localparam logic [7:0] RP8  = 8'(T_RP);

    typedef logic [COL_ADDR_WIDTH-1:0] col_t;

    function automatic logic [2:0] low_mask(input logic [1:0] code);
        return 3'((4'd1 << code) - 4'd1);
    endfunction

    function automatic col_t burst_col(input col_t base, input logic [2:0] idx,
                                       input logic [1:0] code);
        col_t m;
        m = col_t'(low_mask(code));
        return (base & ~m) | ((base + col_t'(idx)) & m);
    endfunction

    logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_ADDR_WIDTH)-1];

    logic                                mode_valid, cl3, wr_single;
    logic [1:0]                          bl_code;
    logic [NB-1:0]                       open_q;
    logic [NB-1:0][ROW_ADDR_WIDTH-1:0]   row_q;
    logic [NB-1:0][7:0]                  rcd_cnt, rp_cnt;
    logic                                b_act, b_wr, b_ap;
    logic [BANK_ADDR_WIDTH-1:0]          b_bank, ap_bank;
    logic [ROW_ADDR_WIDTH-1:0]           b_row;
    col_t                                b_col;
    logic [2:0]                          b_idx;
    logic [1:0]                          b_code;
    logic                                ap_pend;
    logic                                s1_v, s2_v;
    logic [MEM_ADDR_WIDTH-1:0]           s1_a, s2_a;
    logic [DATA_WIDTH-1:0]               dq_out;
    logic [NL-1:0]                       dq_oe, dqm_q;
    logic                                err_pulse;
    logic [2:0]                          err_code_q, err_code;
    logic [15:0]                         ref_cnt;

    logic       cmd_v;
    logic [2:0] cmd;
    logic       c_act, c_rd, c_wr, c_bt, c_pre, c_ref, c_lmr, c_rw;
    logic       bank_open, rw_ok, bl_ok, cl_ok;
    logic [1:0] cmd_code;

    assign cmd_v     = i_Cke & ~i_Cs_n;
    assign cmd       = {i_Ras_n, i_Cas_n, i_We_n};
    assign c_act     = cmd_v && cmd == 3'b011;
    assign c_rd      = cmd_v && cmd == 3'b101;
    assign c_wr      = cmd_v && cmd == 3'b100;
    assign c_bt      = cmd_v && cmd == 3'b110;
    assign c_pre     = cmd_v && cmd == 3'b010;
    assign c_ref     = cmd_v && cmd == 3'b001;
    assign c_lmr     = cmd_v && cmd == 3'b000;
    assign c_rw      = c_rd | c_wr;
    assign bank_open = open_q[i_Ba];
    assign rw_ok     = c_rw & bank_open;
    assign bl_ok     = ~i_Addr[2];
    assign cl_ok     = i_Addr[6:4] == 3'd2 || i_Addr[6:4] == 3'd3;
    assign cmd_code  = (c_wr && wr_single) ? 2'd0 : bl_code;

    logic                       beat_v, beat_wr, beat_last, beat_ap;
    logic [BANK_ADDR_WIDTH-1:0] beat_bank;
    logic [ROW_ADDR_WIDTH-1:0]  beat_row;
    col_t                       beat_col;
    logic [MEM_ADDR_WIDTH-1:0]  beat_addr;

    // Current data beat: a fresh READ/WRITE beat 0 or the running burst.
    always_comb begin
        beat_v    = 1'b0;
        beat_wr   = 1'b0;
        beat_last = 1'b0;
        beat_ap   = 1'b0;
        beat_bank = i_Ba;
        beat_row  = row_q[i_Ba];
        beat_col  = i_Addr[COL_ADDR_WIDTH-1:0];
        if (rw_ok) begin
            beat_v    = 1'b1;
            beat_wr   = c_wr;
            beat_last = cmd_code == 2'd0;
            beat_ap   = i_Addr[10];
        end else if (i_Cke && b_act && !c_bt) begin
            beat_v    = 1'b1;
            beat_wr   = b_wr;
            beat_bank = b_bank;
            beat_row  = b_row;
            beat_col  = burst_col(b_col, b_idx, b_code);
            beat_last = b_idx == low_mask(b_code);
            beat_ap   = b_ap;
        end
    end

    assign beat_addr = MEM_ADDR_WIDTH'({beat_row, beat_bank, beat_col});

    // Violation priority: later assignments are lower codes and win.
    always_comb begin
        err_code = 3'd0;
        if (c_lmr && !(bl_ok && cl_ok))         err_code = 3'd7;
        if (c_ref && |open_q)                   err_code = 3'd6;
        if (c_act && rp_cnt[i_Ba] < RP8)        err_code = 3'd5;
        if (c_rw && rcd_cnt[i_Ba] < RCD8)       err_code = 3'd4;
        if (c_act && bank_open)                 err_code = 3'd3;
        if (c_rw && !bank_open)                 err_code = 3'd2;
        if ((c_act || c_rw) && !mode_valid)     err_code = 3'd1;
    end

    // Backing RAM write port with per-lane masking; never reset.
    always_ff @(posedge i_Clk) begin
        if (beat_v && beat_wr)
            for (int i = 0; i < NL; i++)
                if (!i_Dqm[i])
                    mem[beat_addr][8*i +: 8] <= b_Dq[8*i +: 8];
    end

    // Command execution, bank timing, burst engine and read pipeline.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            mode_valid <= 1'b0;
            cl3        <= 1'b1;
            bl_code    <= 2'd0;
            wr_single  <= 1'b0;
            open_q     <= '0;
            row_q      <= '0;
            rcd_cnt    <= '1;
            rp_cnt     <= '1;
            b_act      <= 1'b0;
            b_wr       <= 1'b0;
            b_ap       <= 1'b0;
            b_bank     <= '0;
            b_row      <= '0;
            b_col      <= '0;
            b_idx      <= '0;
            b_code     <= '0;
            ap_pend    <= 1'b0;
            ap_bank    <= '0;
            s1_v       <= 1'b0;
            s2_v       <= 1'b0;
            s1_a       <= '0;
            s2_a       <= '0;
            dq_out     <= '0;
            dq_oe      <= '0;
            dqm_q      <= '0;
            err_pulse  <= 1'b0;
            err_code_q <= 3'd0;
            ref_cnt    <= 16'd0;
        end else begin
            err_pulse <= err_code != 3'd0;
            if (err_code != 3'd0)
                err_code_q <= err_code;
            if (i_Cke) begin
                dqm_q <= i_Dqm;
                for (int b = 0; b < NB; b++) begin
                    if (rcd_cnt[b] != 8'hFF) rcd_cnt[b] <= rcd_cnt[b] + 8'd1;
                    if (rp_cnt[b] != 8'hFF)  rp_cnt[b]  <= rp_cnt[b] + 8'd1;
                end
                if (ap_pend) begin
                    open_q[ap_bank] <= 1'b0;
                    rp_cnt[ap_bank] <= 8'd1;
                end
                ap_pend <= beat_v && beat_last && beat_ap;
                ap_bank <= beat_bank;
                if (c_act) begin
                    open_q[i_Ba]  <= 1'b1;
                    row_q[i_Ba]   <= i_Addr;
                    rcd_cnt[i_Ba] <= 8'd1;
                end
                if (c_pre) begin
                    if (i_Addr[10]) begin
                        open_q <= '0;
                        for (int b = 0; b < NB; b++) rp_cnt[b] <= 8'd1;
                    end else begin
                        open_q[i_Ba] <= 1'b0;
                        rp_cnt[i_Ba] <= 8'd1;
                    end
                end
                if (c_ref && ref_cnt != 16'hFFFF)
                    ref_cnt <= ref_cnt + 16'd1;
                if (c_lmr) begin
                    mode_valid <= 1'b1;
                    wr_single  <= i_Addr[9];
                    if (bl_ok) bl_code <= i_Addr[1:0];
                    if (cl_ok) cl3 <= i_Addr[4];
                end
                if (rw_ok) begin
                    b_act  <= cmd_code != 2'd0;
                    b_wr   <= c_wr;
                    b_ap   <= i_Addr[10];
                    b_bank <= i_Ba;
                    b_row  <= row_q[i_Ba];
                    b_col  <= i_Addr[COL_ADDR_WIDTH-1:0];
                    b_idx  <= 3'd1;
                    b_code <= cmd_code;
                end else if (c_bt || (b_act && beat_last)) begin
                    b_act <= 1'b0;
                end else if (b_act) begin
                    b_idx <= b_idx + 3'd1;
                end
                s1_v <= beat_v && !beat_wr;
                s1_a <= beat_addr;
                s2_a <= s1_a;
                if (rw_ok && c_wr) begin
                    s2_v  <= 1'b0;
                    dq_oe <= '0;
                end else begin
                    s2_v <= s1_v;
                    if (cl3 ? s2_v : s1_v) begin
                        dq_out <= mem[cl3 ? s2_a : s1_a];
                        dq_oe  <= ~dqm_q;
                    end else begin
                        dq_oe <= '0;
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NL; i++) begin : g_dq
        assign b_Dq[8*i +: 8] = dq_oe[i] ? dq_out[8*i +: 8] : 8'bz;
    end

    assign o_Mode_Valid    = mode_valid;
    assign o_Open_Banks    = open_q;
    assign o_Err_Pulse     = err_pulse;
    assign o_Err_Code      = err_code_q;
    assign o_Refresh_Count = ref_cnt;

endmodule

// File: tb/tb_sdram_device_emulator.sv
// Directed bench for sdram_device_emulator.
// A released bus reads back as all ones through the pulled-up net.
module tb_sdram_device_emulator;
    localparam logic [2:0] C_NOP = 3'b111;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_LMR = 3'b000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    tri1  [15:0] dq;
    logic [15:0] tb_dq = '0;
    logic        tb_oe = 1'b0;
    logic [11:0] addr = '0;
    logic [1:0]  ba = '0;
    logic        cke = 1'b1;
    logic        cs_n = 1'b0;
    logic        ras_n = 1'b1;
    logic        cas_n = 1'b1;
    logic        we_n = 1'b1;
    logic [1:0]  dqm = '0;
    logic        mode_valid;
    logic [3:0]  open_banks;
    logic        err_pulse;
    logic [2:0]  err_code;
    logic [15:0] ref_cnt;

    int vec = 0;
    int bad = 0;
    int err_seen = 0;

    assign dq = tb_oe ? tb_dq : 16'hzzzz;

    always #5 clk = ~clk;

    always @(negedge clk) if (err_pulse === 1'b1) err_seen++;

    sdram_device_emulator dut (
        .i_Clk(clk),
        .i_Reset_n(rst_n),
        .b_Dq(dq),
        .i_Addr(addr),
        .i_Ba(ba),
        .i_Cke(cke),
        .i_Cs_n(cs_n),
        .i_Ras_n(ras_n),
        .i_Cas_n(cas_n),
        .i_We_n(we_n),
        .i_Dqm(dqm),
        .o_Mode_Valid(mode_valid),
        .o_Open_Banks(open_banks),
        .o_Err_Pulse(err_pulse),
        .o_Err_Code(err_code),
        .o_Refresh_Count(ref_cnt)
    );

    task automatic issue(input logic [2:0] c, input logic [1:0] b,
                         input logic [11:0] a);
        {ras_n, cas_n, we_n} = c;
        ba = b;
        addr = a;
        @(posedge clk);
        #1;
        {ras_n, cas_n, we_n} = C_NOP;
    endtask

    task automatic nop(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_burst(input logic [1:0] b, input logic [11:0] a,
                               input logic [15:0] d0, input int mbeat,
                               input logic [1:0] mval);
        tb_oe = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tb_dq = d0 + 16'(k);
            dqm = (k == mbeat) ? mval : 2'b00;
            if (k == 0) begin
                {ras_n, cas_n, we_n} = C_WR;
                ba = b;
                addr = a;
            end
            @(posedge clk);
            #1;
            {ras_n, cas_n, we_n} = C_NOP;
        end
        tb_oe = 1'b0;
        dqm = 2'b00;
    endtask

    task automatic init_seq(input int nref);
        issue(C_PRE, 2'd0, 12'h400);
        nop(2);
        for (int i = 0; i < nref; i++) begin
            issue(C_REF, 2'd0, 12'h000);
            nop(9);
        end
        issue(C_LMR, 2'd0, 12'h033);
        nop(2);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        nop(3);
        vec++;
        if (dq !== 16'hFFFF) begin
            bad++;
            $display("FAIL rst_dq: got %h want ffff", dq);
        end
        vec++;
        if ({mode_valid, open_banks, err_pulse, err_code, ref_cnt} !== '0) begin
            bad++;
            $display("FAIL rst_outs: mv=%b ob=%b ep=%b ec=%0d rc=%0d want 0",
                     mode_valid, open_banks, err_pulse, err_code, ref_cnt);
        end
        rst_n = 1'b1;
        nop(2);
    endtask

    task automatic test_init;
        int e0;
        e0 = err_seen;
        init_seq(8);
        vec++;
        if (mode_valid !== 1'b1) begin
            bad++;
            $display("FAIL init_mv: got %b want 1", mode_valid);
        end
        vec++;
        if (ref_cnt !== 16'd8) begin
            bad++;
            $display("FAIL init_ref: got %0d want 8", ref_cnt);
        end
        vec++;
        if (err_seen !== e0) begin
            bad++;
            $display("FAIL init_err: got %0d pulses want 0", err_seen - e0);
        end
    endtask

    task automatic test_write_read;
        int e0;
        logic [15:0] exp;
        e0 = err_seen;
        issue(C_ACT, 2'd1, 12'd5);
        nop(2);
        write_burst(2'd1, 12'h010, 16'h1000, -1, 2'b00);
        issue(C_RD, 2'd1, 12'h410);
        for (int j = 1; j <= 10; j++) begin
            @(posedge clk);
            #1;
            exp = (j >= 2 && j <= 9) ? 16'h1000 + 16'(j - 2) : 16'hFFFF;
            vec++;
            if (dq !== exp) begin
                bad++;
                $display("FAIL wr_rd_edge%0d: got %h want %h", j, dq, exp);
            end
            if (j == 7 || j == 8) begin
                vec++;
                if (open_banks[1] !== (j == 7)) begin
                    bad++;
                    $display("FAIL ap_edge%0d: open1=%b want %b",
                             j, open_banks[1], j == 7);
                end
            end
        end
        vec++;
        if (err_seen !== e0) begin
            bad++;
            $display("FAIL wr_rd_err: got %0d pulses want 0", err_seen - e0);
        end
    endtask

    task automatic test_wrap;
        logic [15:0] exp;
        issue(C_ACT, 2'd1, 12'd5);
        nop(2);
        issue(C_RD, 2'd1, 12'h016);
        for (int j = 1; j <= 10; j++) begin
            @(posedge clk);
            #1;
            if (j >= 2 && j <= 9) begin
                exp = 16'h1000 + 16'((6 + j - 2) % 8);
                vec++;
                if (dq !== exp) begin
                    bad++;
                    $display("FAIL wrap_beat%0d: got %h want %h", j - 2, dq, exp);
                end
            end
        end
    endtask

    task automatic test_dqm;
        logic [15:0] exp;
        issue(C_RD, 2'd1, 12'h010);
        dqm = 2'b01;
        @(posedge clk);
        #1;
        dqm = 2'b00;
        for (int j = 2; j <= 10; j++) begin
            @(posedge clk);
            #1;
            if (j == 2 || j == 3) begin
                exp = (j == 2) ? 16'h10FF : 16'h1001;
                vec++;
                if (dq !== exp) begin
                    bad++;
                    $display("FAIL rd_dqm_beat%0d: got %h want %h", j - 2, dq, exp);
                end
            end
        end
        write_burst(2'd1, 12'h010, 16'h20A0, 2, 2'b10);
        issue(C_RD, 2'd1, 12'h010);
        for (int j = 1; j <= 10; j++) begin
            @(posedge clk);
            #1;
            if (j >= 2 && j <= 9) begin
                exp = (j == 4) ? 16'h10A2 : 16'h20A0 + 16'(j - 2);
                vec++;
                if (dq !== exp) begin
                    bad++;
                    $display("FAIL wr_dqm_beat%0d: got %h want %h", j - 2, dq, exp);
                end
            end
        end
    endtask

    task automatic test_violations;
        int driven;
        issue(C_RD, 2'd2, 12'h000);
        vec++;
        if (err_pulse !== 1'b1 || err_code !== 3'd2) begin
            bad++;
            $display("FAIL err_closed: pulse=%b code=%0d want 1/2", err_pulse, err_code);
        end
        driven = 0;
        for (int j = 0; j < 6; j++) begin
            nop(1);
            if (dq !== 16'hFFFF) driven++;
        end
        vec++;
        if (driven != 0) begin
            bad++;
            $display("FAIL closed_dq: driven %0d cycles want 0", driven);
        end
        issue(C_ACT, 2'd2, 12'd7);
        vec++;
        if (err_pulse !== 1'b0) begin
            bad++;
            $display("FAIL act_ok: pulse=%b want 0", err_pulse);
        end
        nop(1);
        issue(C_RD, 2'd2, 12'h000);
        vec++;
        if (err_pulse !== 1'b1 || err_code !== 3'd4) begin
            bad++;
            $display("FAIL err_rcd: pulse=%b code=%0d want 1/4", err_pulse, err_code);
        end
        nop(11);
        issue(C_REF, 2'd0, 12'h000);
        vec++;
        if (err_pulse !== 1'b1 || err_code !== 3'd6) begin
            bad++;
            $display("FAIL err_ref: pulse=%b code=%0d want 1/6", err_pulse, err_code);
        end
        vec++;
        if (ref_cnt !== 16'd9 || open_banks !== 4'b0110) begin
            bad++;
            $display("FAIL ref_open: cnt=%0d ob=%b want 9/0110", ref_cnt, open_banks);
        end
        issue(C_LMR, 2'd0, 12'h073);
        vec++;
        if (err_pulse !== 1'b1 || err_code !== 3'd7) begin
            bad++;
            $display("FAIL err_mode: pulse=%b code=%0d want 1/7", err_pulse, err_code);
        end
        nop(1);
        vec++;
        if (err_pulse !== 1'b0 || err_code !== 3'd7) begin
            bad++;
            $display("FAIL err_hold: pulse=%b code=%0d want 0/7", err_pulse, err_code);
        end
    endtask

    task automatic test_reset_mid_read;
        logic [15:0] exp;
        issue(C_RD, 2'd1, 12'h010);
        nop(3);
        vec++;
        if (dq !== 16'h20A1) begin
            bad++;
            $display("FAIL pre_rst_beat: got %h want 20a1", dq);
        end
        #1 rst_n = 1'b0;
        #1;
        vec++;
        if (dq !== 16'hFFFF) begin
            bad++;
            $display("FAIL rst_mid_dq: got %h want ffff", dq);
        end
        vec++;
        if ({mode_valid, open_banks, err_pulse, err_code, ref_cnt} !== '0) begin
            bad++;
            $display("FAIL rst_mid_outs: mv=%b ob=%b ep=%b ec=%0d rc=%0d want 0",
                     mode_valid, open_banks, err_pulse, err_code, ref_cnt);
        end
        nop(3);
        rst_n = 1'b1;
        nop(1);
        init_seq(2);
        vec++;
        if (mode_valid !== 1'b1 || ref_cnt !== 16'd2) begin
            bad++;
            $display("FAIL reinit: mv=%b rc=%0d want 1/2", mode_valid, ref_cnt);
        end
        issue(C_ACT, 2'd1, 12'd5);
        nop(2);
        issue(C_RD, 2'd1, 12'h010);
        for (int j = 1; j <= 10; j++) begin
            @(posedge clk);
            #1;
            if (j >= 2 && j <= 9) begin
                exp = (j == 4) ? 16'h10A2 : 16'h20A0 + 16'(j - 2);
                vec++;
                if (dq !== exp) begin
                    bad++;
                    $display("FAIL keep_beat%0d: got %h want %h", j - 2, dq, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_wrap();
        test_dqm();
        test_violations();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

// File: doc/sdram_device_emulator.md
Name: sdram_device_emulator

Overview:
- Synthesizable single-rank SDR SDRAM responder: decodes the command bus driven by the team's SDRAM controller, keeps per-bank row state, honours the mode register (CAS latency, burst length), and serves read/write bursts from an on-chip backing RAM.
- Sits on the controller's SDRAM pins in FPGA regression builds and simulation, in place of the board chip.
- Flags protocol and timing violations for the verification bench.

Parameters:
- ROW_ADDR_WIDTH, 12, row address bits (i_Addr width).
- BANK_ADDR_WIDTH, 2, bank bits; bank count NB = 2**BANK_ADDR_WIDTH.
- COL_ADDR_WIDTH, 8, column bits used from i_Addr.
- DATA_WIDTH, 16, DQ width; multiple of 8.
- MEM_ADDR_WIDTH, 12, log2 of backing-RAM depth in DATA_WIDTH words.
- T_RCD, 3, minimum cycles from ACTIVE to READ/WRITE on the same bank.
- T_RP, 3, minimum cycles from PRECHARGE to ACTIVE on the same bank.

Ports:
- i_Clk  in  1  clock, same as controller o_Clk.
- i_Reset_n  in  1  asynchronous, active-low reset.
- b_Dq  inout  DATA_WIDTH  data bus; driven only during read data beats.
- i_Addr  in  ROW_ADDR_WIDTH  row / column / opcode.
- i_Ba  in  BANK_ADDR_WIDTH  bank select.
- i_Cke, i_Cs_n, i_Ras_n, i_Cas_n, i_We_n  in  1 each  command pins.
- i_Dqm  in  DATA_WIDTH/8  byte masks.
- o_Mode_Valid  out  1  mode register loaded at least once.
- o_Open_Banks  out  NB  bit b set while bank b has an open row.
- o_Err_Pulse  out  1  one-cycle pulse per violation.
- o_Err_Code  out  3  code of the most recent violation.
- o_Refresh_Count  out  16  saturating AUTO REFRESH count.

Behaviour:
- Reset (async, i_Reset_n low): all outputs 0, all banks closed, bursts and read pipeline cleared, b_Dq released immediately. Mode defaults to CL=3, BL=1. Backing RAM is not cleared.
- Sampling and decode: commands are sampled on rising i_Clk only when i_Cke=1 and i_Cs_n=0. i_Cke=0 freezes all state (burst counters, pipeline, driver). i_Cs_n=1 is treated as NOP.
- Command encoding {Ras_n,Cas_n,We_n}: 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 110 BURST TERMINATE, 010 PRECHARGE (A10=1: all banks, else i_Ba), 001 AUTO REFRESH, 000 LOAD MODE.
- LOAD MODE:
  - A[2:0] burst length: 000=1, 001=2, 010=4, 011=8; other codes are an error and leave BL unchanged.
  - A[6:4] CAS latency: 2 or 3 accepted; other values are an error and leave CL unchanged.
  - A[9]=1 selects single-location writes.
  - Burst type is ignored; bursts are always sequential.
  - o_Mode_Valid is set on every LOAD MODE.
- Memory word index: low MEM_ADDR_WIDTH bits of {row, bank, col}. Aliasing above the RAM depth is intended.
- Burst column order: low log2(BL) column bits count mod BL; upper column bits stay fixed (wrap inside the aligned block).
- WRITE issued at edge T0:
  - Beat k is captured at edge T0+k, k = 0..BL-1; BL is forced to 1 when A[9]=1.
  - A byte lane is written only if its i_Dqm bit is 0 at that same edge.
- READ issued at edge T0:
  - Beat k is driven so that it is stable at edge T0+CL+k; output register and enable update at edge T0+CL-1+k.
  - Read DQM latency is 2: i_Dqm=1 at edge T tri-states that lane for the beat sampled at T+2.
- Auto-precharge: A10=1 on READ/WRITE closes the bank at the edge after the last beat address is generated.
- Burst interruption:
  - A new READ or BURST TERMINATE truncates the current burst; read beats already in the CL pipeline still emerge, and a following read burst continues seamlessly.
  - A new WRITE truncates the current burst and flushes the read pipeline, releasing b_Dq the same cycle.
- Errors: each violation pulses o_Err_Pulse and loads o_Err_Code.
  - 1: READ/WRITE/ACTIVE before any LOAD MODE. The command still executes.
  - 2: READ/WRITE to a closed bank. The command is ignored.
  - 3: ACTIVE to an open bank. The new row replaces the old one.
  - 4: READ/WRITE fewer than T_RCD cycles after ACTIVE. The command executes.
  - 5: ACTIVE fewer than T_RP cycles after PRECHARGE of that bank. The command executes.
  - 6: AUTO REFRESH with any bank open. The refresh is counted and banks are unchanged.
  - 7: unsupported mode field.
- Simultaneous violations: lowest code wins.
- o_Refresh_Count increments on each AUTO REFRESH and holds at 0xFFFF.

Test Plan:
- Init sequence (PRECHARGE all, 8x AUTO REFRESH 10 cycles apart, LOAD MODE 0x0033) -> o_Mode_Valid=1, o_Refresh_Count=8, no error pulse.
- ACTIVE bank1 row 5; WRITE col 0x10 A10=0 with data 0x1000..0x1007; READ col 0x10 A10=1 at T0 -> 0x1000..0x1007 stable at edges T0+3..T0+10; o_Open_Banks[1] clears after the last beat.
- BL=8 READ at col 0x16 -> beat order cols 6,7,0,1,2,3,4,5 of block 0x10.
- READ with i_Dqm=2'b01 at edge T0+1 -> beat 0 lower byte is Z, upper byte valid; WRITE with i_Dqm=2'b10 on beat 2 -> only the low byte of that word changes.
- Violations: READ to closed bank -> pulse with code 2 and b_Dq never driven; READ 2 cycles after ACTIVE -> code 4; AUTO REFRESH with a bank open -> code 6 and count +1.
- Assert i_Reset_n low mid read burst -> b_Dq goes Z the same cycle, all outputs 0, RAM contents survive (re-init then read returns the prior data).
